// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters,
// with per-frame locking and a start/active/done handshake toward the transmitter.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_begin,
    output logic [7:0]             tx_data,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic [2:0]             owner,
    output logic                   locked,
    output logic                   busy
);

    typedef enum logic [1:0] {ARB, START, WAIT_DONE, HOLD} state_t;

    localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]  RR_INIT  = 3'(NUM_REQ - 1);

    state_t             state, state_nxt;
    logic [2:0]         rr_ptr, rr_ptr_nxt;
    logic [15:0]        cnt, cnt_nxt;
    logic [NUM_REQ-1:0] req_ack_nxt;
    logic               tx_begin_nxt, locked_nxt, busy_nxt;
    logic [7:0]         tx_data_nxt;
    logic [2:0]         owner_nxt;

    logic [2:0] win;
    logic       win_found, win_last;
    logic [7:0] win_byte;
    logic       own_valid, own_last;
    logic [7:0] own_byte;
    logic       arb_issue, hold_issue, issue, hold_tmo;
    logic [2:0] iss_idx;
    logic [7:0] iss_byte;
    logic       iss_last;

    // Scan from the farthest candidate back to rr_ptr+1 so the nearest valid one wins.
    always_comb begin : rr_search
        int idx;
        win       = '0;
        win_found = 1'b0;
        win_byte  = '0;
        win_last  = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                win       = 3'(idx);
                win_found = 1'b1;
                win_byte  = req_data[8*idx +: 8];
                win_last  = req_last[idx];
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_byte  = '0;
        own_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == 3'(i)) begin
                own_valid = req_valid[i];
                own_byte  = req_data[8*i +: 8];
                own_last  = req_last[i];
            end
        end
    end

    assign arb_issue  = (state == ARB) && !tx_active && win_found;
    assign hold_issue = (state == HOLD) && own_valid;
    assign issue      = arb_issue || hold_issue;
    assign hold_tmo   = (state == HOLD) && !own_valid && (cnt == TMO_LAST);
    assign iss_idx    = hold_issue ? owner    : win;
    assign iss_byte   = hold_issue ? own_byte : win_byte;
    assign iss_last   = hold_issue ? own_last : win_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            rr_ptr   <= RR_INIT;
            cnt      <= '0;
            owner    <= '0;
            tx_data  <= '0;
            tx_begin <= 1'b0;
            req_ack  <= '0;
            locked   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            cnt      <= cnt_nxt;
            owner    <= owner_nxt;
            tx_data  <= tx_data_nxt;
            tx_begin <= tx_begin_nxt;
            req_ack  <= req_ack_nxt;
            locked   <= locked_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:       if (arb_issue) state_nxt = START;
            START:     if (tx_active) state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_done || !tx_active) state_nxt = locked ? HOLD : ARB;
            HOLD: begin
                if (hold_issue)    state_nxt = START;
                else if (hold_tmo) state_nxt = ARB;
            end
            default:   state_nxt = ARB;
        endcase
    end

    always_comb begin
        tx_begin_nxt = issue;
        tx_data_nxt  = issue ? iss_byte : tx_data;
        owner_nxt    = issue ? iss_idx  : owner;
        rr_ptr_nxt   = issue ? iss_idx  : rr_ptr;
        locked_nxt   = locked;
        if (issue)         locked_nxt = !iss_last;
        else if (hold_tmo) locked_nxt = 1'b0;
        // Counter only runs while waiting in HOLD; any exit leaves it cleared.
        cnt_nxt = '0;
        if ((state == HOLD) && !issue && !hold_tmo) cnt_nxt = cnt + 16'd1;
        busy_nxt    = (state_nxt != ARB);
        req_ack_nxt = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ack_nxt[i] = issue && (iss_idx == 3'(i));
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a small UART model, queued requesters and a
// transaction-level grant model checked every cycle, plus literal timing/ordering checks.
module tb_uart_tx_arbiter;
    localparam int NR    = 4;
    localparam int LT    = 8;
    localparam int FRAME = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_last  = '0;
    logic [8*NR-1:0] req_data  = '0;
    logic [NR-1:0]   req_ack;
    logic            tx_begin;
    logic [7:0]      tx_data;
    logic            tx_active = 1'b0;
    logic            tx_done   = 1'b0;
    logic [2:0]      owner;
    logic            locked, busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ack(req_ack), .tx_begin(tx_begin), .tx_data(tx_data),
        .tx_active(tx_active), .tx_done(tx_done),
        .owner(owner), .locked(locked), .busy(busy)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // UART transmitter model: accepts a start when idle, active FRAME cycles, done with active fall.
    logic [8:0] txlog[$];
    logic [8:0] exp_q[$];
    int ucnt = 0;
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (tx_active) begin
            if (ucnt == 1) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
            end
            ucnt <= ucnt - 1;
        end else if (tx_begin) begin
            tx_active <= 1'b1;
            ucnt      <= FRAME;
            txlog.push_back({locked, tx_data});
        end
    end

    // Requester byte queues: {last, data}
    logic [8:0] rq [NR][64];
    int rq_head[NR];
    int rq_tail[NR];

    task automatic push(input int i, input logic [7:0] d, input logic l);
        rq[i][rq_tail[i]] = {l, d};
        rq_tail[i]++;
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]        = (rq_head[i] != rq_tail[i]);
            req_last[i]         = rq[i][rq_head[i]][8];
            req_data[8*i +: 8]  = rq[i][rq_head[i]][7:0];
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NR; i++)
            if (req_ack[i] && rq_head[i] != rq_tail[i]) rq_head[i]++;
        apply();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++)
            if (rq_head[i] != rq_tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(all_empty() && !busy && !tx_active) && n < 400) begin
            step();
            n++;
        end
        chk(nm, 32'(n < 400), 1);
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, txlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", nm, i),
                (i < txlog.size()) ? 32'(txlog[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        txlog.delete();
        exp_q.delete();
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_begin"},  tx_begin, 0);
        chk({nm, "_ack"},    req_ack,  0);
        chk({nm, "_owner"},  owner,    0);
        chk({nm, "_data"},   tx_data,  0);
        chk({nm, "_locked"}, locked,   0);
        chk({nm, "_busy"},   busy,     0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Grant model: snapshot of inputs at each edge, abstract rr/lock state.
    logic [NR-1:0]   s_valid, s_last;
    logic [8*NR-1:0] s_data;
    logic rst_q   = 1'b1;
    int   m_rr    = NR - 1;
    bit   m_lock  = 1'b0;
    int   m_owner = 0;
    int   cyc = 0;
    int   last_done = 0;

    always @(posedge clk) begin
        s_valid = req_valid;
        s_last  = req_last;
        s_data  = req_data;
        rst_q   = rst;
        if (rst) begin
            m_rr    = NR - 1;
            m_lock  = 1'b0;
            m_owner = 0;
        end
    end

    always @(negedge clk) begin : cmp
        int w;
        cyc++;
        if (tx_done) last_done = cyc;
        if (!rst_q) begin
            chk("ack_onehot", 32'($onehot0(req_ack)), 1);
            chk("begin_eq_ack", tx_begin, |req_ack);
            if (tx_begin) begin
                w = -1;
                if (m_lock) begin
                    if (s_valid[m_owner]) w = m_owner;
                end else begin
                    for (int k = NR; k >= 1; k--)
                        if (s_valid[(m_rr + k) % NR]) w = (m_rr + k) % NR;
                end
                chk("grant_legal", 32'(w >= 0), 1);
                if (w >= 0) begin
                    chk("grant_ack",   req_ack, 1 << w);
                    chk("grant_owner", owner,   w);
                    chk("grant_data",  tx_data, s_data[8*w +: 8]);
                    chk("grant_lock",  locked,  !s_last[w]);
                    chk("begin_tx_idle", tx_active, 0);
                    m_rr    = w;
                    m_owner = w;
                    m_lock  = !s_last[w];
                end
            end else if (m_lock && !locked) begin
                chk("lock_timeout", 32'((cyc - last_done) >= LT), 1);
                m_lock = 1'b0;
            end else begin
                chk("locked", locked, m_lock);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < NR; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        rst = 1'b1;
        step();
        step();
        check_reset("rst0");
        rst = 1'b0;

        // Single byte from requester 0
        push(0, 8'h30, 1'b1);
        apply();
        chk("t1_pre_begin", tx_begin, 0);
        step();
        chk("t1_begin", tx_begin, 1);
        chk("t1_ack",   req_ack,  4'b0001);
        chk("t1_data",  tx_data,  8'h30);
        chk("t1_owner", owner,    0);
        chk("t1_busy",  busy,     1);
        step();
        chk("t1_begin_pulse", tx_begin, 0);
        chk("t1_ack_pulse",   req_ack,  0);
        wait_idle("t1_idle");
        exp_q.push_back(9'h030);
        check_log("t1_log");

        // All four requesters valid, single-byte frames
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) begin
                push(i, 8'(8'h41 + i), 1'b1);
                exp_q.push_back({1'b0, 8'(8'h41 + i)});
            end
        apply();
        wait_idle("t2_idle");
        check_log("t2_log");

        // 3-byte locked frame from requester 2 while requester 0 stays valid
        do_reset();
        push(0, 8'h10, 1'b1);
        push(0, 8'h11, 1'b1);
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        apply();
        wait_idle("t3_idle");
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h120);
        exp_q.push_back(9'h121);
        exp_q.push_back(9'h022);
        exp_q.push_back(9'h011);
        check_log("t3_log");

        // Lock timeout: requester 1 stalls mid-frame, requester 3 waits
        do_reset();
        push(1, 8'h51, 1'b0);
        push(3, 8'h53, 1'b1);
        apply();
        n = 0;
        while (!tx_done && n < 40) begin
            step();
            n++;
        end
        chk("t4_done_seen", tx_done, 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 8) chk("t4_still_locked", locked, 1);
            if (k == 9) begin
                chk("t4_released", locked,   0);
                chk("t4_idle",     busy,     0);
                chk("t4_no_begin", tx_begin, 0);
            end
            if (k == 10) begin
                chk("t4_begin", tx_begin, 1);
                chk("t4_ack",   req_ack,  4'b1000);
                chk("t4_data",  tx_data,  8'h53);
            end
        end
        wait_idle("t4_idle");
        exp_q.push_back(9'h151);
        exp_q.push_back(9'h053);
        check_log("t4_log");

        // Reset mid-transmission with requester 0 still valid
        push(0, 8'h60, 1'b1);
        push(0, 8'h61, 1'b1);
        apply();
        n = 0;
        while (!tx_active && n < 20) begin
            step();
            n++;
        end
        chk("t5_active", tx_active, 1);
        rst = 1'b1;
        step();
        check_reset("t5_rst");
        rst = 1'b0;
        n = 0;
        while (tx_active && n < 20) begin
            step();
            n++;
            chk("t5_hold_off", tx_begin, 0);
        end
        chk("t5_active_fell", tx_active, 0);
        step();
        chk("t5_begin", tx_begin, 1);
        chk("t5_ack",   req_ack,  4'b0001);
        chk("t5_data",  tx_data,  8'h61);
        wait_idle("t5_idle");
        exp_q.push_back(9'h060);
        exp_q.push_back(9'h061);
        check_log("t5_log");

        // Requester 3 raises valid in the tx_done cycle
        push(1, 8'h71, 1'b1);
        apply();
        n = 0;
        while (!tx_done && n < 40) begin
            step();
            n++;
        end
        chk("t6_done_seen", tx_done, 1);
        push(3, 8'h73, 1'b1);
        apply();
        step();
        chk("t6_gap", tx_begin, 0);
        step();
        chk("t6_begin", tx_begin, 1);
        chk("t6_ack",   req_ack,  4'b1000);
        chk("t6_data",  tx_data,  8'h73);
        wait_idle("t6_idle");
        exp_q.push_back(9'h071);
        exp_q.push_back(9'h073);
        check_log("t6_log");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
